// File: rtl/emergency_request_conditioner_if.sv
// emergency_request_conditioner_if: raw detector/override inputs and conditioned emergency outputs.
interface emergency_request_conditioner_if;
    logic       det_raw;
    logic       force_emg;
    logic       fault_clr;
    logic       emergency;
    logic [2:0] state_o;
    logic       fault;
    logic [7:0] event_count;
    modport master (output det_raw, force_emg, fault_clr, input emergency, state_o, fault, event_count);
    modport slave  (input det_raw, force_emg, fault_clr, output emergency, state_o, fault, event_count);
endinterface

// File: rtl/emergency_request_conditioner.sv
// emergency_request_conditioner: synchronises/debounces the emergency detector, enforces hold and
// cooldown, and latches a fault when the detector sticks high.
module emergency_request_conditioner #(
    parameter int DEB_CYCLES      = 4,
    parameter int HOLD_CYCLES     = 20,
    parameter int COOLDOWN_CYCLES = 10,
    parameter int MAX_ACTIVE      = 200,
    parameter int CNT_W           = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    emergency_request_conditioner_if.slave bus
);
    typedef enum logic [2:0] {IDLE = 3'd0, ARMING = 3'd1, ACTIVE = 3'd2, COOLDOWN = 3'd3, FAULT = 3'd4} state_t;
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_FULL  = CNT_W'(DEB_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(MAX_ACTIVE - 1);
    localparam logic [CNT_W-1:0] CD_LAST   = CNT_W'(COOLDOWN_CYCLES - 1);
    state_t           r_state, w_next;
    logic             r_sync1, r_det_s;
    logic [CNT_W-1:0] r_deb_cnt, r_hold_cnt, r_rel_cnt, r_tmo_cnt, r_cd_cnt;
    logic [CNT_W-1:0] w_deb_cnt, w_hold_cnt, w_rel_cnt, w_tmo_cnt, w_cd_cnt, w_rel_step;
    logic             r_fault, w_fault, w_event_inc, r_emergency;
    logic [7:0]       r_event_count;
    // release debounce: run of consecutive low det_s cycles while ACTIVE
    assign w_rel_step = r_det_s ? '0 : (r_rel_cnt == DEB_FULL ? r_rel_cnt : r_rel_cnt + 1'b1);
    always_comb begin
        w_next      = r_state;
        w_deb_cnt   = r_deb_cnt;
        w_hold_cnt  = r_hold_cnt;
        w_rel_cnt   = r_rel_cnt;
        w_tmo_cnt   = r_tmo_cnt;
        w_cd_cnt    = r_cd_cnt;
        w_fault     = r_fault;
        w_event_inc = 1'b0;
        if (bus.force_emg) begin
            w_next      = ACTIVE;
            w_hold_cnt  = '0;
            w_tmo_cnt   = '0;
            w_rel_cnt   = (r_state == ACTIVE) ? w_rel_step : '0;
            w_event_inc = (r_state != ACTIVE);
        end else begin
            case (r_state)
                IDLE: if (r_det_s) begin
                    w_next    = ARMING;
                    w_deb_cnt = '0;
                end
                ARMING: if (!r_det_s) w_next = IDLE;
                else if (r_deb_cnt == DEB_LAST) begin
                    w_next      = ACTIVE;
                    w_hold_cnt  = '0;
                    w_tmo_cnt   = '0;
                    w_rel_cnt   = '0;
                    w_event_inc = 1'b1;
                end else w_deb_cnt = r_deb_cnt + 1'b1;
                ACTIVE: begin
                    w_hold_cnt = (r_hold_cnt == HOLD_LAST) ? r_hold_cnt : r_hold_cnt + 1'b1;
                    w_rel_cnt  = w_rel_step;
                    w_tmo_cnt  = r_det_s ? r_tmo_cnt + 1'b1 : r_tmo_cnt;
                    // a completed release outranks the stuck-detector timeout
                    if (r_hold_cnt == HOLD_LAST && r_rel_cnt == DEB_FULL) begin
                        w_next   = COOLDOWN;
                        w_cd_cnt = '0;
                    end else if (r_tmo_cnt == TMO_LAST && r_det_s) begin
                        w_next  = FAULT;
                        w_fault = 1'b1;
                    end
                end
                COOLDOWN: if (r_cd_cnt == CD_LAST) w_next = IDLE;
                else w_cd_cnt = r_cd_cnt + 1'b1;
                FAULT: if (bus.fault_clr && !r_det_s) begin
                    w_next   = COOLDOWN;
                    w_cd_cnt = '0;
                    w_fault  = 1'b0;
                end
                default: w_next = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1       <= 1'b0;
            r_det_s       <= 1'b0;
            r_state       <= IDLE;
            r_deb_cnt     <= '0;
            r_hold_cnt    <= '0;
            r_rel_cnt     <= '0;
            r_tmo_cnt     <= '0;
            r_cd_cnt      <= '0;
            r_fault       <= 1'b0;
            r_emergency   <= 1'b0;
            r_event_count <= '0;
        end else begin
            r_sync1     <= bus.det_raw;
            r_det_s     <= r_sync1;
            r_state     <= w_next;
            r_deb_cnt   <= w_deb_cnt;
            r_hold_cnt  <= w_hold_cnt;
            r_rel_cnt   <= w_rel_cnt;
            r_tmo_cnt   <= w_tmo_cnt;
            r_cd_cnt    <= w_cd_cnt;
            r_fault     <= w_fault;
            r_emergency <= (w_next == ACTIVE);
            if (w_event_inc && r_event_count != 8'hFF) r_event_count <= r_event_count + 8'd1;
        end
    end
    assign bus.emergency   = r_emergency;
    assign bus.state_o     = r_state;
    assign bus.fault       = r_fault;
    assign bus.event_count = r_event_count;
endmodule

// File: tb/tb_emergency_request_conditioner.sv
// tb_emergency_request_conditioner: vector table, directed corner sequences and random stimulus
// checked against a run-length reference model of the conditioner.
module tb_emergency_request_conditioner;
    localparam int DEB = 4, HOLD = 20, CD = 10, MAXA = 200;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    emergency_request_conditioner_if bus();
    emergency_request_conditioner #(.DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .COOLDOWN_CYCLES(CD),
        .MAX_ACTIVE(MAXA), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    typedef struct {
        logic det;
        logic frc;
        logic clr;
        int   st;
        int   emg;
        int   flt;
        int   evt;
    } vec_t;
    vec_t tbl[10];
    int total = 0, bad = 0;
    // model: state, cycles since state entry, consecutive low det_s run in ACTIVE, det-high ACTIVE cycles
    int m_state, m_run, m_low, m_hits, m_evt, m_fault, m_s1, m_s2;
    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    function automatic int sat(int v, int lim);
        return (v < lim) ? v + 1 : lim;
    endfunction
    task automatic model_reset();
        m_state = 0; m_run = 0; m_low = 0; m_hits = 0; m_evt = 0; m_fault = 0; m_s1 = 0; m_s2 = 0;
    endtask
    task automatic model_step(int d, int f, int c);
        int ds;
        bit held, released, stuck;
        ds = m_s2; m_s2 = m_s1; m_s1 = d;
        if (f != 0) begin
            if (m_state != 2) begin m_evt = sat(m_evt, 255); m_low = 0; end
            else m_low = ds ? 0 : sat(m_low, DEB);
            m_state = 2; m_run = 0; m_hits = 0;
        end else case (m_state)
            0: if (ds != 0) begin m_state = 1; m_run = 0; end
            1: if (ds == 0) m_state = 0;
               else if (m_run == DEB - 1) begin
                   m_state = 2; m_run = 0; m_hits = 0; m_low = 0; m_evt = sat(m_evt, 255);
               end else m_run++;
            2: begin
                held = (m_run >= HOLD - 1);
                released = (m_low >= DEB);
                stuck = (ds != 0) && (m_hits >= MAXA - 1);
                m_run++;
                m_hits += ds;
                m_low = ds ? 0 : sat(m_low, DEB);
                if (held && released) begin m_state = 3; m_run = 0; end
                else if (stuck) begin m_state = 4; m_fault = 1; m_run = 0; end
            end
            3: if (m_run == CD - 1) m_state = 0; else m_run++;
            4: if (c != 0 && ds == 0) begin m_state = 3; m_run = 0; m_fault = 0; end
            default: m_state = 0;
        endcase
    endtask
    task automatic tick();
        int d, f, c;
        d = bus.det_raw; f = bus.force_emg; c = bus.fault_clr;
        @(posedge clk);
        model_step(d, f, c);
        #1;
        check("model_state", bus.state_o, m_state);
        check("model_emergency", bus.emergency, m_state == 2);
        check("model_fault", bus.fault, m_fault);
        check("model_event_count", bus.event_count, m_evt);
    endtask
    task automatic do_reset();
        bus.det_raw = 1'b0; bus.force_emg = 1'b0; bus.fault_clr = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask
    initial begin
        int lat, emg_n, cd_n, len;
        tbl[0] = '{1'b1, 1'b0, 1'b0, 0, 0, 0, 0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 0, 0, 0, 0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1, 0, 0, 0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1, 0, 0, 0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1, 0, 0, 0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 2, 1, 0, 1};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 2, 1, 0, 1};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 2, 1, 0, 1};
        tbl[9] = '{1'b0, 1'b0, 1'b1, 2, 1, 0, 1};
        do_reset();
        check("reset_state", bus.state_o, 0);
        check("reset_emergency", bus.emergency, 0);
        check("reset_fault", bus.fault, 0);
        check("reset_event_count", bus.event_count, 0);
        for (int i = 0; i < 10; i++) begin
            bus.det_raw = tbl[i].det; bus.force_emg = tbl[i].frc; bus.fault_clr = tbl[i].clr;
            tick();
            check($sformatf("vec%0d_state", i), bus.state_o, tbl[i].st);
            check($sformatf("vec%0d_emergency", i), bus.emergency, tbl[i].emg);
            check($sformatf("vec%0d_fault", i), bus.fault, tbl[i].flt);
            check($sformatf("vec%0d_event_count", i), bus.event_count, tbl[i].evt);
        end
        do_reset();
        lat = -1; emg_n = 0; cd_n = 0;
        bus.det_raw = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.emergency && lat < 0) lat = i;
            emg_n += int'(bus.emergency);
        end
        bus.det_raw = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            emg_n += int'(bus.emergency);
            cd_n += int'(bus.state_o == 3'd3);
        end
        check("clean_latency", lat, 7);
        check("clean_emergency_cycles", emg_n, 40);
        check("clean_cooldown_cycles", cd_n, 10);
        check("clean_final_state", bus.state_o, 0);
        check("clean_event_count", bus.event_count, 1);
        do_reset();
        emg_n = 0; cd_n = 0;
        bus.det_raw = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (i == 10) bus.det_raw = 1'b0;
            tick();
            emg_n += int'(bus.emergency);
            cd_n += int'(bus.state_o == 3'd3);
        end
        check("short_emergency_cycles", emg_n, 20);
        check("short_cooldown_cycles", cd_n, 10);
        check("short_final_state", bus.state_o, 0);
        do_reset();
        emg_n = 0;
        bus.det_raw = 1'b1;
        for (int i = 0; i < 400 && bus.state_o != 3'd4; i++) begin
            tick();
            emg_n += int'(bus.emergency);
        end
        check("stuck_active_cycles", emg_n, 200);
        check("stuck_state", bus.state_o, 4);
        check("stuck_emergency", bus.emergency, 0);
        check("stuck_fault", bus.fault, 1);
        bus.fault_clr = 1'b1;
        tick();
        bus.fault_clr = 1'b0;
        check("clr_while_high_state", bus.state_o, 4);
        check("clr_while_high_fault", bus.fault, 1);
        bus.det_raw = 1'b0;
        tick();
        tick();
        bus.fault_clr = 1'b1;
        tick();
        bus.fault_clr = 1'b0;
        check("clr_accept_state", bus.state_o, 3);
        check("clr_accept_fault", bus.fault, 0);
        bus.force_emg = 1'b1;
        tick();
        bus.force_emg = 1'b0;
        check("force_cooldown_state", bus.state_o, 2);
        check("force_cooldown_event_count", bus.event_count, 2);
        bus.force_emg = 1'b1;
        tick();
        bus.force_emg = 1'b0;
        check("force_active_state", bus.state_o, 2);
        check("force_active_event_count", bus.event_count, 2);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_emergency", bus.emergency, 0);
        check("async_reset_state", bus.state_o, 0);
        check("async_reset_event_count", bus.event_count, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        lat = -1;
        bus.det_raw = 1'b1;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            tick();
            if (bus.emergency) lat = i;
        end
        check("post_reset_latency", lat, 7);
        do_reset();
        for (int i = 0; i < 260; i++) begin
            bus.force_emg = 1'b1;
            tick();
            bus.force_emg = 1'b0;
            repeat (24) tick();
        end
        check("event_count_saturated", bus.event_count, 255);
        do_reset();
        len = 0;
        for (int i = 0; i < 4000; i++) begin
            if (len == 0) begin
                bus.det_raw = 1'($urandom_range(0, 1));
                len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(150, 260)) : int'($urandom_range(1, 30));
            end
            len--;
            bus.force_emg = ($urandom_range(0, 99) == 0);
            bus.fault_clr = ($urandom_range(0, 7) == 0);
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
